instruction_prefetch_buffer: RTL and testbench

Sequential instruction prefetcher between the Grande_Risco5 fetch port and instruction memory. It keeps up to DEPTH consecutive instruction words ahead of the core PC, so the fetch stage sees a hit on sequential flow. The block detects redirects (jal, jalr, taken branch) by comparing the core address against its head tag, then flushes and refetches. The core side connects directly to instruction_address / instruction_response / instruction_data.

---
 rtl/instruction_prefetch_buffer_if.sv | 21 ++
 rtl/instruction_prefetch_buffer.sv | 127 ++++++++++++
 tb/tb_instruction_prefetch_buffer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_prefetch_buffer_if.sv
// Core fetch port plus instruction-memory read port of the prefetch buffer.
// master: the prefetch buffer itself; slave: the core/memory side.
interface instruction_prefetch_buffer_if;
    logic [31:0] core_address;
    logic        core_response;
    logic [31:0] core_data;
    logic        mem_read;
    logic [31:0] mem_address;
    logic        mem_response;
    logic [31:0] mem_data;

    modport master (
        input  core_address, mem_response, mem_data,
        output core_response, core_data, mem_read, mem_address
    );

    modport slave (
        output core_address, mem_response, mem_data,
        input  core_response, core_data, mem_read, mem_address
    );
endinterface

// File: rtl/instruction_prefetch_buffer.sv
// Sequential instruction prefetcher: a small FIFO of consecutive words ahead of the core PC,
// flushed and refilled whenever the core address leaves the sequential stream.
module instruction_prefetch_buffer #(
    parameter int unsigned DEPTH        = 4,
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input logic                           clk,
    input logic                           reset,
    instruction_prefetch_buffer_if.master bus
);
    localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW   = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
    localparam logic [31:0] Nop    = 32'h0000_0033;

    typedef enum logic [1:0] {StIdle, StFetch, StDiscard} state_e;

    state_e            state_q, state_d;
    logic [31:0]       data_q [DEPTH];
    logic [31:0]       data_d [DEPTH];
    logic [PtrW-1:0]   head_q, head_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [31:0]       head_addr_q, head_addr_d;
    logic [31:0]       fetch_addr_q, fetch_addr_d;
    logic              mem_read_q, mem_read_d;
    logic [31:0]       mem_address_q, mem_address_d;

    logic              hit, advance, redirect;
    logic [PtrW-1:0]   tail;

    assign hit      = (count_q != '0) && (bus.core_address == head_addr_q);
    assign advance  = (count_q != '0) && (bus.core_address == head_addr_q + 32'd4);
    assign redirect = (bus.core_address != head_addr_q) && !advance;
    // DEPTH is a power of two, so the pointer sum wraps naturally.
    assign tail     = head_q + count_q[PtrW-1:0];

    assign bus.core_response = hit;
    assign bus.core_data     = hit ? data_q[head_q] : Nop;
    assign bus.mem_read      = mem_read_q;
    assign bus.mem_address   = mem_address_q;

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        head_d        = head_q;
        count_d       = count_q;
        head_addr_d   = head_addr_q;
        fetch_addr_d  = fetch_addr_q;
        mem_read_d    = mem_read_q;
        mem_address_d = mem_address_q;

        if (redirect) begin
            count_d      = '0;
            head_addr_d  = bus.core_address;
            fetch_addr_d = bus.core_address;
        end else if (advance) begin
            head_d      = head_q + PtrW'(1);
            head_addr_d = head_addr_q + 32'd4;
            count_d     = count_q - CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (redirect) begin
                    mem_read_d    = 1'b1;
                    mem_address_d = bus.core_address;
                    state_d       = StFetch;
                end else if (count_q < DepthC) begin
                    mem_read_d    = 1'b1;
                    mem_address_d = fetch_addr_q;
                    state_d       = StFetch;
                end
            end
            StFetch: begin
                if (bus.mem_response) begin
                    if (redirect) begin
                        mem_address_d = bus.core_address;
                    end else begin
                        data_d[tail] = bus.mem_data;
                        fetch_addr_d = fetch_addr_q + 32'd4;
                        count_d      = advance ? count_q : count_q + CntW'(1);
                        if (count_d < DepthC) begin
                            mem_address_d = fetch_addr_q + 32'd4;
                        end else begin
                            mem_read_d = 1'b0;
                            state_d    = StIdle;
                        end
                    end
                end else if (redirect) begin
                    // Outstanding read is never abandoned; its data is dropped on arrival.
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                if (bus.mem_response) begin
                    mem_address_d = fetch_addr_d;
                    state_d       = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            head_q        <= '0;
            count_q       <= '0;
            head_addr_q   <= BOOT_ADDRESS;
            fetch_addr_q  <= BOOT_ADDRESS;
            mem_read_q    <= 1'b0;
            mem_address_q <= BOOT_ADDRESS;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            count_q       <= count_d;
            head_addr_q   <= head_addr_d;
            fetch_addr_q  <= fetch_addr_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end
endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Bench for instruction_prefetch_buffer: memory model returning address>>2 with
// configurable latency, a core model that steps on hits, and a queue of expected words.
module tb_instruction_prefetch_buffer;
    localparam logic [31:0] Nop = 32'h0000_0033;

    logic clk = 1'b0;
    logic reset;
    instruction_prefetch_buffer_if bus_if ();

    instruction_prefetch_buffer #(
        .DEPTH        (4),
        .BOOT_ADDRESS (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned mem_lat     = 1;
    logic [31:0] exp_q [$];

    // Memory: accepts a read one tick after it is visible, answers mem_lat cycles later.
    logic        mem_busy;
    int unsigned mem_cnt;
    logic [31:0] mem_addr_l;
    initial begin
        bus_if.mem_response = 1'b0;
        bus_if.mem_data     = 32'h0;
        mem_busy            = 1'b0;
        mem_cnt             = 0;
        mem_addr_l          = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus_if.mem_response = 1'b0;
            if (reset) begin
                mem_busy = 1'b0;
            end else if (mem_busy) begin
                if (mem_cnt == 0) begin
                    bus_if.mem_response = 1'b1;
                    bus_if.mem_data     = mem_addr_l >> 2;
                    mem_busy            = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end else if (bus_if.mem_read === 1'b1) begin
                mem_busy   = 1'b1;
                mem_addr_l = bus_if.mem_address;
                mem_cnt    = mem_lat - 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset(input logic [31:0] addr);
        reset               = 1'b1;
        bus_if.core_address = addr;
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic early;
        mem_lat             = 1;
        reset               = 1'b1;
        bus_if.core_address = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus_if.core_response !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_core_response got=%b exp=0", bus_if.core_response);
        end
        vectors++;
        if (bus_if.core_data !== Nop) begin
            miscompares++;
            $display("FAIL rst_core_data got=%h exp=%h", bus_if.core_data, Nop);
        end
        vectors++;
        if (bus_if.mem_read !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mem_read got=%b exp=0", bus_if.mem_read);
        end
        vectors++;
        if (bus_if.mem_address !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_mem_address got=%h exp=0", bus_if.mem_address);
        end
        reset = 1'b0;
        early = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (bus_if.core_response !== 1'b0) early = 1'b1;
            if (c == 1) begin
                vectors++;
                if (bus_if.mem_read !== 1'b1 || bus_if.mem_address !== 32'h0) begin
                    miscompares++;
                    $display("FAIL first_request got=%b/%h exp=1/00000000",
                             bus_if.mem_read, bus_if.mem_address);
                end
            end
        end
        vectors++;
        if (early !== 1'b0) begin
            miscompares++;
            $display("FAIL early_response got=%b exp=0", early);
        end
        @(negedge clk);
        vectors++;
        if (bus_if.core_response !== 1'b1 || bus_if.core_data !== 32'h0) begin
            miscompares++;
            $display("FAIL first_hit_cycle3 got=%b/%h exp=1/00000000",
                     bus_if.core_response, bus_if.core_data);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] addr;
        logic [31:0] exp;
        int          words;
        logic        dropped;
        logic        nop_bad;
        mem_lat = 1;
        do_reset(32'h0);
        addr    = 32'h0;
        exp_q.push_back(addr >> 2);
        words   = 0;
        dropped = 1'b0;
        nop_bad = 1'b0;
        for (int c = 0; c < 200 && words < 16; c++) begin
            @(negedge clk);
            if (bus_if.mem_read !== 1'b1) dropped = 1'b1;
            if (bus_if.core_response === 1'b1) begin
                exp = exp_q.pop_front();
                vectors++;
                if (bus_if.core_data !== exp) begin
                    miscompares++;
                    $display("FAIL seq_data addr=%h got=%h exp=%h", addr, bus_if.core_data, exp);
                end
                words++;
                addr += 32'd4;
                bus_if.core_address = addr;
                exp_q.push_back(addr >> 2);
            end else if (bus_if.core_data !== Nop) begin
                nop_bad = 1'b1;
            end
        end
        vectors++;
        if (words != 16) begin
            miscompares++;
            $display("FAIL seq_timeout got=%0d words exp=16", words);
        end
        vectors++;
        if (dropped !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_mem_read_dropped got=%b exp=0", dropped);
        end
        vectors++;
        if (nop_bad !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_nop_when_miss got=%b exp=0", nop_bad);
        end
        exp_q.delete();
    endtask

    task automatic test_stall_back_to_back();
        logic found;
        logic bad;
        mem_lat = 1;
        do_reset(32'h0);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (bus_if.core_response === 1'b1) begin
                if (bus_if.core_address == 32'h10) found = 1'b1;
                else bus_if.core_address = bus_if.core_address + 32'd4;
            end
        end
        vectors++;
        if (found !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_reach_0x10 got=%b exp=1", found);
        end
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus_if.core_response !== 1'b1 || bus_if.core_data !== 32'h4) bad = 1'b1;
        end
        vectors++;
        if (bad !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold_hit got=%b exp=0 (data %h)", bad, bus_if.core_data);
        end
        vectors++;
        if (bus_if.mem_read !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_full_mem_read got=%b exp=0", bus_if.mem_read);
        end
        bus_if.core_address = 32'h14;
        @(negedge clk);
        vectors++;
        if (bus_if.core_response !== 1'b1 || bus_if.core_data !== 32'h5) begin
            miscompares++;
            $display("FAIL release_hit got=%b/%h exp=1/00000005",
                     bus_if.core_response, bus_if.core_data);
        end
        found = 1'b0;
        for (int c = 0; c < 5 && !found; c++) begin
            @(negedge clk);
            if (bus_if.mem_read === 1'b1) found = 1'b1;
        end
        vectors++;
        if (found !== 1'b1 || bus_if.mem_address !== 32'h20) begin
            miscompares++;
            $display("FAIL resume_addr got=%b/%h exp=1/00000020", found, bus_if.mem_address);
        end
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (bus_if.mem_response === 1'b1) found = 1'b1;
        end
        // Pop in the same cycle as the push, with three entries queued.
        bus_if.core_address = 32'h18;
        @(negedge clk);
        vectors++;
        if (found !== 1'b1 || bus_if.mem_read !== 1'b1 || bus_if.mem_address !== 32'h24) begin
            miscompares++;
            $display("FAIL push_pop_no_bubble got=%b/%b/%h exp=1/1/00000024",
                     found, bus_if.mem_read, bus_if.mem_address);
        end
        vectors++;
        if (bus_if.core_response !== 1'b1 || bus_if.core_data !== 32'h6) begin
            miscompares++;
            $display("FAIL push_pop_hit got=%b/%h exp=1/00000006",
                     bus_if.core_response, bus_if.core_data);
        end
    endtask

    task automatic test_redirect_pending();
        logic        found;
        logic        early;
        logic [31:0] exp;
        mem_lat = 3;
        do_reset(32'h0);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (bus_if.mem_read === 1'b1 && bus_if.mem_address == 32'h18 &&
                bus_if.mem_response === 1'b0) begin
                found = 1'b1;
            end else if (bus_if.core_response === 1'b1) begin
                bus_if.core_address = bus_if.core_address + 32'd4;
            end
        end
        vectors++;
        if (found !== 1'b1) begin
            miscompares++;
            $display("FAIL redir_pending_0x18 got=%b exp=1", found);
        end
        bus_if.core_address = 32'h100;
        exp_q.push_back(32'h100 >> 2);
        early = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (bus_if.core_response !== 1'b0) early = 1'b1;
            if (bus_if.mem_response === 1'b1) found = 1'b1;
        end
        @(negedge clk);
        vectors++;
        if (found !== 1'b1 || bus_if.mem_read !== 1'b1 || bus_if.mem_address !== 32'h100) begin
            miscompares++;
            $display("FAIL redir_next_addr got=%b/%b/%h exp=1/1/00000100",
                     found, bus_if.mem_read, bus_if.mem_address);
        end
        vectors++;
        if (early !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_stale_response got=%b exp=0", early);
        end
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (c > 0) @(negedge clk);
            if (bus_if.core_response === 1'b1) begin
                found = 1'b1;
                exp   = exp_q.pop_front();
                vectors++;
                if (bus_if.core_data !== exp) begin
                    miscompares++;
                    $display("FAIL redir_first_hit got=%h exp=%h", bus_if.core_data, exp);
                end
            end
        end
        vectors++;
        if (found !== 1'b1) begin
            miscompares++;
            $display("FAIL redir_hit_timeout got=%b exp=1", found);
        end
        exp_q.delete();
    endtask

    task automatic test_redirect_with_response();
        logic        found;
        logic        saw300;
        logic        captured;
        logic [31:0] next_addr;
        logic [31:0] exp;
        mem_lat = 2;
        do_reset(32'h0);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (bus_if.mem_response === 1'b1) found = 1'b1;
        end
        bus_if.core_address = 32'h200;
        @(negedge clk);
        vectors++;
        if (found !== 1'b1 || bus_if.mem_read !== 1'b1 || bus_if.mem_address !== 32'h200) begin
            miscompares++;
            $display("FAIL coincide_next_addr got=%b/%b/%h exp=1/1/00000200",
                     found, bus_if.mem_read, bus_if.mem_address);
        end
        bus_if.core_address = 32'h300;
        @(negedge clk);
        vectors++;
        if (bus_if.mem_response !== 1'b0) begin
            miscompares++;
            $display("FAIL discard_window got=%b exp=0", bus_if.mem_response);
        end
        bus_if.core_address = 32'h400;
        exp_q.push_back(32'h400 >> 2);
        saw300   = 1'b0;
        captured = 1'b0;
        next_addr = 32'h0;
        found    = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            if (bus_if.mem_read === 1'b1 && bus_if.mem_address == 32'h300) saw300 = 1'b1;
            if (!captured && bus_if.mem_read === 1'b1 && bus_if.mem_address != 32'h200) begin
                captured  = 1'b1;
                next_addr = bus_if.mem_address;
            end
            if (bus_if.core_response === 1'b1) begin
                found = 1'b1;
                exp   = exp_q.pop_front();
                vectors++;
                if (bus_if.core_data !== exp) begin
                    miscompares++;
                    $display("FAIL second_target_hit got=%h exp=%h", bus_if.core_data, exp);
                end
            end
        end
        vectors++;
        if (next_addr !== 32'h400) begin
            miscompares++;
            $display("FAIL second_target_addr got=%h exp=00000400", next_addr);
        end
        vectors++;
        if (saw300 !== 1'b0 || found !== 1'b1) begin
            miscompares++;
            $display("FAIL first_target_skipped got=%b/%b exp=0/1", saw300, found);
        end
        exp_q.delete();
    endtask

    task automatic test_wrap();
        logic found;
        logic saw0;
        mem_lat = 1;
        do_reset(32'hFFFF_FFFC);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (bus_if.core_response === 1'b1) found = 1'b1;
        end
        vectors++;
        if (found !== 1'b1 || bus_if.core_data !== 32'h3FFF_FFFF) begin
            miscompares++;
            $display("FAIL wrap_first_hit got=%b/%h exp=1/3fffffff", found, bus_if.core_data);
        end
        saw0  = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 15 && !found; c++) begin
            @(negedge clk);
            if (bus_if.mem_read === 1'b1 && bus_if.mem_address == 32'h0) saw0 = 1'b1;
            if (bus_if.mem_read === 1'b0) found = 1'b1;
        end
        vectors++;
        if (saw0 !== 1'b1 || found !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_prefetch got=%b/%b exp=1/1", saw0, found);
        end
        bus_if.core_address = 32'h0;
        @(negedge clk);
        vectors++;
        if (bus_if.core_response !== 1'b1 || bus_if.core_data !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_advance_hit got=%b/%h exp=1/00000000",
                     bus_if.core_response, bus_if.core_data);
        end
        @(negedge clk);
        vectors++;
        if (bus_if.mem_read !== 1'b1 || bus_if.mem_address !== 32'hC) begin
            miscompares++;
            $display("FAIL wrap_refill got=%b/%h exp=1/0000000c",
                     bus_if.mem_read, bus_if.mem_address);
        end
    endtask

    initial begin
        reset               = 1'b1;
        bus_if.core_address = 32'h0;
        test_reset();
        test_sequential();
        test_stall_back_to_back();
        test_redirect_pending();
        test_redirect_with_response();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
